// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// lsu_pkg : shared tag constants, tag packing and clog2 helper for the LSU
// Revision : 1.0
// ============================================================================
package lsu_pkg;

    localparam int unsigned ID_W         = 3;
    localparam int unsigned TAG_W        = 8;
    localparam logic [2:0]  MEM_TYPE     = 3'b100;
    localparam logic [3:0]  ACC_TAG_MARK = 4'b1000;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic logic [TAG_W-1:0] pack_acceptor_tag(input logic            ready,
                                                           input logic [ID_W-1:0] id);
        return {ready, ACC_TAG_MARK, id};
    endfunction

    function automatic logic [TAG_W-1:0] pack_result_tag(input logic [ID_W-1:0] id);
        return {1'b1, MEM_TYPE, 1'b0, id};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_prio_enc.sv
`default_nettype none
// ============================================================================
// lsu_prio_enc : lowest-index-set priority encoder returning {found, index}
// Revision : 1.0
// ============================================================================
module lsu_prio_enc
    import lsu_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = ID_W
) (
    input  logic [N-1:0]     vec_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scanning downward lets the lowest set bit win.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    assign found_o = |vec_i;

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// load_store_unit : load buffer with fixed latency, internal word memory and
//                   CDB grant handshake
// Revision : 1.0
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 16,
    parameter int MEM_WORDS   = 256,
    parameter int LATENCY     = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              rden,
    input  logic              wren,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready_for_instr,
    output logic [TAG_W-1:0]  acceptor_tag,
    output logic              data_out_valid,
    output logic [DATA_W-1:0] data_out,
    output logic [TAG_W-1:0]  reg_tag_out,
    input  logic              cdb_grant
);

    localparam int MEM_AW = clog2(MEM_WORDS);
    localparam int CNT_W  = clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(LATENCY);

    logic [DATA_W-1:0]      mem_q  [MEM_WORDS];
    logic [NUM_ENTRIES-1:0] busy_q;
    logic [NUM_ENTRIES-1:0] busy_d;
    logic [CNT_W-1:0]       cnt_q  [NUM_ENTRIES];
    logic [CNT_W-1:0]       cnt_d  [NUM_ENTRIES];
    logic [DATA_W-1:0]      data_q [NUM_ENTRIES];
    logic [DATA_W-1:0]      data_d [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] w_ready_vec;
    logic                   w_acc_found;
    logic [ID_W-1:0]        w_acc_id;
    logic                   w_sel_found;
    logic [ID_W-1:0]        w_sel_id;
    logic [MEM_AW-1:0]      w_mem_idx;
    logic [DATA_W-1:0]      w_mem_rd;
    logic                   w_load_fire;
    logic                   w_store_fire;
    logic                   w_release;

    assign w_mem_idx    = addr_in[MEM_AW-1:0];
    assign w_mem_rd     = mem_q[w_mem_idx];
    assign w_load_fire  = en & rden & w_acc_found;
    assign w_store_fire = en & wren;
    assign w_release    = en & w_sel_found & cdb_grant;

    // Upper address bits alias onto the memory and are deliberately ignored.
    if (MEM_AW < ADDR_W) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^addr_in[ADDR_W-1:MEM_AW];
    end

    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_ready
        assign w_ready_vec[gi] = busy_q[gi] && (cnt_q[gi] == CNT_DONE);
    end

    lsu_prio_enc #(
        .N     (NUM_ENTRIES),
        .IDX_W (ID_W)
    ) u_acc_enc (
        .vec_i   (~busy_q),
        .found_o (w_acc_found),
        .idx_o   (w_acc_id)
    );

    lsu_prio_enc #(
        .N     (NUM_ENTRIES),
        .IDX_W (ID_W)
    ) u_sel_enc (
        .vec_i   (w_ready_vec),
        .found_o (w_sel_found),
        .idx_o   (w_sel_id)
    );

    // The acceptor is always a free entry and the released one always busy,
    // so accept and release in the same cycle never target the same entry.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (en && busy_q[i] && (cnt_q[i] != CNT_DONE)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
            if (w_load_fire && (w_acc_id == ID_W'(i))) begin
                busy_d[i] = 1'b1;
                cnt_d[i]  = '0;
                data_d[i] = w_mem_rd;
            end
            if (w_release && (w_sel_id == ID_W'(i))) begin
                busy_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                cnt_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                cnt_q[i]  <= cnt_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    // Snapshot above reads mem_q before this write lands: same-cycle load sees old data.
    always_ff @(posedge clk) begin
        if (w_store_fire) begin
            mem_q[w_mem_idx] <= data_in;
        end
    end

    always_comb begin
        data_out = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (w_sel_found && (w_sel_id == ID_W'(i))) begin
                data_out = data_q[i];
            end
        end
    end

    assign data_out_valid  = w_sel_found;
    assign reg_tag_out     = w_sel_found ? pack_result_tag(w_sel_id) : '0;
    assign ready_for_instr = w_acc_found;
    assign acceptor_tag    = pack_acceptor_tag(w_acc_found, w_acc_id);

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// tb_load_store_unit : table vectors plus scoreboard of expected load results
// Revision : 1.0
// ============================================================================
module tb_load_store_unit;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        en        = 1'b0;
    logic        rden      = 1'b0;
    logic        wren      = 1'b0;
    logic [15:0] addr_in   = '0;
    logic [31:0] data_in   = '0;
    logic        cdb_grant = 1'b0;
    logic        ready_for_instr;
    logic [7:0]  acceptor_tag;
    logic        data_out_valid;
    logic [31:0] data_out;
    logic [7:0]  reg_tag_out;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk             (clk),
        .reset           (reset),
        .en              (en),
        .rden            (rden),
        .wren            (wren),
        .addr_in         (addr_in),
        .data_in         (data_in),
        .ready_for_instr (ready_for_instr),
        .acceptor_tag    (acceptor_tag),
        .data_out_valid  (data_out_valid),
        .data_out        (data_out),
        .reg_tag_out     (reg_tag_out),
        .cdb_grant       (cdb_grant)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  tag;
    } sb_t;

    typedef struct {
        logic [15:0] st_addr;
        logic [15:0] ld_addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vecs[6];
    int   checks = 0;
    int   passed = 0;
    int   n;

    function automatic logic [7:0] acc_tag(input logic rdy, input logic [2:0] id);
        return {rdy, 4'b1000, id};
    endfunction

    function automatic logic [7:0] res_tag(input logic [2:0] id);
        return {1'b1, 3'b100, 1'b0, id};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // Inputs are stable at the negedge; a grant seen here is the one the next edge consumes.
    always @(negedge clk) begin
        if (!reset && en && data_out_valid && cdb_grant) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_result", {24'h0, reg_tag_out}, 64'hFFFF);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                chk("sb_data", data_out, e.data);
                chk("sb_tag", reg_tag_out, e.tag);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [15:0] a, input logic [31:0] d);
        wren    = 1'b1;
        addr_in = a;
        data_in = d;
        tick();
        wren = 1'b0;
    endtask

    task automatic issue_load(input logic [15:0] a, input logic [31:0] exp_d, input logic [2:0] id);
        chk("acc_ready", ready_for_instr, 1'b1);
        chk("acc_tag", acceptor_tag, acc_tag(1'b1, id));
        sb_q.push_back('{data: exp_d, tag: res_tag(id)});
        rden    = 1'b1;
        addr_in = a;
        tick();
        rden = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int cnt);
        cnt = 0;
        while (!data_out_valid && cnt < budget) begin
            tick();
            cnt++;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        cdb_grant = 1'b1;
        while ((sb_q.size() != 0 || data_out_valid) && k < 100) begin
            tick();
            k++;
        end
        cdb_grant = 1'b0;
        chk("drain_sb_empty", sb_q.size(), 0);
    endtask

    initial begin
        vecs[0] = '{16'h0001, 16'h0001, 32'h0000_0000, 32'h0000_0000};
        vecs[1] = '{16'h00FF, 16'h00FF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[2] = '{16'h0103, 16'h0003, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
        vecs[3] = '{16'hFF40, 16'h0040, 32'h5A5A_0001, 32'h5A5A_0001};
        vecs[4] = '{16'h0207, 16'h0307, 32'h1111_1111, 32'h2222_2222};
        vecs[5] = '{16'h0007, 16'h0007, 32'h2222_2222, 32'h2222_2222};

        tick();
        tick();
        chk("rst_valid", data_out_valid, 1'b0);
        chk("rst_data", data_out, 32'h0);
        chk("rst_tag", reg_tag_out, 8'h00);
        chk("rst_ready", ready_for_instr, 1'b1);
        chk("rst_acc_tag", acceptor_tag, acc_tag(1'b1, 3'd0));
        reset = 1'b0;
        en    = 1'b1;

        // Basic latency with grant held high
        store(16'd5, 32'hDEAD_BEEF);
        cdb_grant = 1'b1;
        issue_load(16'd5, 32'hDEAD_BEEF, 3'd0);
        wait_valid(20, n);
        chk("lat_edges", n, 7);
        chk("lat_data", data_out, 32'hDEAD_BEEF);
        chk("lat_tag", reg_tag_out, res_tag(3'd0));
        tick();
        chk("lat_released", data_out_valid, 1'b0);
        chk("lat_acc_free", acceptor_tag, acc_tag(1'b1, 3'd0));
        cdb_grant = 1'b0;

        // Table vectors: stores then one load each
        for (int i = 0; i < 6; i++) begin
            store(vecs[i].st_addr, vecs[i].data);
        end
        for (int i = 0; i < 6; i++) begin
            issue_load(vecs[i].ld_addr, vecs[i].exp, 3'd0);
            wait_valid(20, n);
            chk("vec_valid", data_out_valid, 1'b1);
            chk("vec_data", data_out, vecs[i].exp);
            drain();
        end

        // Fill all eight entries, then release one per cycle
        for (int i = 0; i < 8; i++) begin
            store(16'(20 + i), 32'h1000_0000 + 32'(i) * 32'h0101_0101);
        end
        for (int i = 0; i < 8; i++) begin
            issue_load(16'(20 + i), 32'h1000_0000 + 32'(i) * 32'h0101_0101, 3'(i));
        end
        chk("full_ready", ready_for_instr, 1'b0);
        chk("full_acc_tag", acceptor_tag, acc_tag(1'b0, 3'd0));
        rden    = 1'b1;
        addr_in = 16'd20;
        tick();
        rden = 1'b0;
        chk("full_ignored", ready_for_instr, 1'b0);
        wait_valid(20, n);
        cdb_grant = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("order_valid", data_out_valid, 1'b1);
            chk("order_tag", reg_tag_out, res_tag(3'(i)));
            tick();
        end
        cdb_grant = 1'b0;
        chk("order_done_valid", data_out_valid, 1'b0);
        chk("order_done_ready", ready_for_instr, 1'b1);
        chk("order_sb_empty", sb_q.size(), 0);

        // Same-cycle load and store to one address returns the old word
        store(16'd9, 32'd1);
        chk("rw_acc_tag", acceptor_tag, acc_tag(1'b1, 3'd0));
        sb_q.push_back('{data: 32'd1, tag: res_tag(3'd0)});
        rden    = 1'b1;
        wren    = 1'b1;
        addr_in = 16'd9;
        data_in = 32'd2;
        tick();
        rden = 1'b0;
        wren = 1'b0;
        drain();
        issue_load(16'd9, 32'd2, 3'd0);
        drain();

        // Grant withheld for 20 cycles
        issue_load(16'd5, 32'hDEAD_BEEF, 3'd0);
        wait_valid(20, n);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hold_valid", data_out_valid, 1'b1);
            chk("hold_data", data_out, 32'hDEAD_BEEF);
            chk("hold_tag", reg_tag_out, res_tag(3'd0));
            chk("hold_busy", acceptor_tag, acc_tag(1'b1, 3'd1));
        end
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;
        chk("hold_released", data_out_valid, 1'b0);
        chk("hold_acc_free", acceptor_tag, acc_tag(1'b1, 3'd0));

        // en=0 freezes counting, acceptance and stores
        store(16'd30, 32'h1234_5678);
        cdb_grant = 1'b1;
        issue_load(16'd30, 32'h1234_5678, 3'd0);
        tick();
        tick();
        tick();
        en      = 1'b0;
        rden    = 1'b1;
        wren    = 1'b1;
        addr_in = 16'd30;
        data_in = 32'h0000_0BAD;
        tick();
        tick();
        tick();
        chk("en0_no_accept", acceptor_tag, acc_tag(1'b1, 3'd1));
        en   = 1'b1;
        rden = 1'b0;
        wren = 1'b0;
        wait_valid(20, n);
        chk("en0_delay", n, 4);
        drain();
        issue_load(16'd30, 32'h1234_5678, 3'd0);
        drain();

        // Asynchronous reset with four loads pending
        for (int i = 0; i < 4; i++) begin
            issue_load(16'd5, 32'hDEAD_BEEF, 3'(i));
        end
        tick();
        tick();
        tick();
        tick();
        chk("pre_rst_valid", data_out_valid, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", data_out_valid, 1'b0);
        chk("arst_data", data_out, 32'h0);
        chk("arst_tag", reg_tag_out, 8'h00);
        chk("arst_ready", ready_for_instr, 1'b1);
        chk("arst_acc_tag", acceptor_tag, acc_tag(1'b1, 3'd0));
        sb_q.delete();
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_valid", data_out_valid, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
